// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// address-width helper and the busy-vector type.
package regfile_sb_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_NREG = 32;

  typedef logic [DEFAULT_NREG-1:0] busy_vec_t;

  // A one-entry file still needs a one-bit address to keep port widths legal.
  function automatic int calc_aw(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_sb_wr_arb.sv
// Write-port select for one address: reports whether any enabled write port
// targets the address and returns the data of the highest-index such port.
module rf_wr_arb #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     data_o
);

  // Ascending scan so later (higher-index) ports overwrite earlier matches.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, a per-register busy
// scoreboard (issue/clear/flush) and a retired-write counter.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int NREG = DEFAULT_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NWR-1:0]      wr_clr_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [31:0]         commit_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [31:0]     commit_q, commit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      commit_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_comb begin
    regs_d   = regs_q;
    commit_d = commit_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
        regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
        commit_d = commit_d + 32'd1;
      end
    end
  end

  // Clear first, then issue, then flush: each later step overrides earlier ones.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && wr_clr_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  assign commit_cnt_o = commit_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] byp_data;

    assign addr = rd_addr_i[k*AW +: AW];

    rf_wr_arb #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_arb (
      .addr_i    (addr),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (hit),
      .data_o    (byp_data)
    );

    // Reset masks the bypass path too, so reads are 0 while rst is high.
    assign rd_data_o[k*XLEN +: XLEN] = (rst || (addr == '0)) ? '0 :
                                       hit ? byp_data : regs_q[addr];
    assign rd_busy_o[k] = !rst && (addr != '0) && busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb: write/read, bypass, port
// conflict, scoreboard issue/clear/flush and asynchronous reset.
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic [2*AW-1:0] rd_addr_i;
  logic [2*XLEN-1:0] rd_data_o;
  logic [1:0]      rd_busy_o;
  logic [1:0]      wr_en_i;
  logic [2*AW-1:0] wr_addr_i;
  logic [2*XLEN-1:0] wr_data_i;
  logic [1:0]      wr_clr_i;
  logic            iss_en_i;
  logic [AW-1:0]   iss_addr_i;
  logic            flush_i;
  logic [31:0]     commit_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]      wr_en;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic [1:0]      clr;
    logic            iss;
    logic [AW-1:0]   ia;
    logic            flush;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] e0, e1;
    logic [1:0]      eb;
    logic [31:0]     ec;
  } vec_t;

  vec_t vecs[$];

  regfile_sb u_dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_busy_o    (rd_busy_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_clr_i     (wr_clr_i),
    .iss_en_i     (iss_en_i),
    .iss_addr_i   (iss_addr_i),
    .flush_i      (flush_i),
    .commit_cnt_o (commit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [1:0] wr_en, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
    input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1, input logic [1:0] clr,
    input logic iss, input logic [AW-1:0] ia, input logic flush,
    input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
    input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1,
    input logic [1:0] eb, input logic [31:0] ec);
    vec_t v;
    v.wr_en = wr_en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.clr = clr; v.iss = iss; v.ia = ia; v.flush = flush;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    wr_en_i    = v.wr_en;
    wr_addr_i  = {v.wa1, v.wa0};
    wr_data_i  = {v.wd1, v.wd0};
    wr_clr_i   = v.clr;
    iss_en_i   = v.iss;
    iss_addr_i = v.ia;
    flush_i    = v.flush;
    rd_addr_i  = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [XLEN-1:0] e0,
                          input logic [XLEN-1:0] e1, input logic [1:0] eb,
                          input logic [31:0] ec);
    checkOutput({tag, " rd0"}, rd_data_o[0 +: XLEN], e0);
    checkOutput({tag, " rd1"}, rd_data_o[XLEN +: XLEN], e1);
    checkOutput({tag, " busy"}, {62'd0, rd_busy_o}, {62'd0, eb});
    checkOutput({tag, " cnt"}, {32'd0, commit_cnt_o}, {32'd0, ec});
  endtask

  initial begin
    // Each row: inputs held for one cycle, outputs checked before that edge.
    //          wr_en  wa0  wd0            wa1  wd1    clr   iss  ia  fl  ra0 ra1 e0             e1             eb     ec
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd5, 5'd0, 64'h0,         64'h0,         2'b00, 0));
    vecs.push_back(mk(2'b11, 5'd5, 64'hDEADBEEF,  5'd0, 64'h1,  2'b00, 0, 5'd0, 0, 5'd0, 5'd1, 64'h0,         64'h0,         2'b00, 0));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd5, 5'd0, 64'hDEADBEEF,  64'h0,         2'b00, 1));
    vecs.push_back(mk(2'b01, 5'd7, 64'h55,        5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd7, 5'd5, 64'h55,        64'hDEADBEEF,  2'b00, 1));
    vecs.push_back(mk(2'b11, 5'd3, 64'h11,        5'd3, 64'h22, 2'b00, 0, 5'd0, 0, 5'd3, 5'd7, 64'h22,        64'h55,        2'b00, 2));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd3, 5'd7, 64'h22,        64'h55,        2'b00, 4));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd9, 0, 5'd9, 5'd3, 64'h0,         64'h22,        2'b00, 4));
    vecs.push_back(mk(2'b01, 5'd9, 64'h99,        5'd0, 64'h0,  2'b01, 1, 5'd9, 0, 5'd9, 5'd3, 64'h99,        64'h22,        2'b01, 4));
    vecs.push_back(mk(2'b01, 5'd9, 64'hAA,        5'd0, 64'h0,  2'b01, 0, 5'd0, 0, 5'd9, 5'd9, 64'hAA,        64'hAA,        2'b11, 5));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd9, 5'd0, 64'hAA,        64'h0,         2'b00, 6));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd0, 0, 5'd0, 5'd9, 64'h0,         64'hAA,        2'b00, 6));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd1, 0, 5'd0, 5'd1, 64'h0,         64'h0,         2'b00, 6));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd2, 0, 5'd1, 5'd2, 64'h0,         64'h0,         2'b01, 6));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd3, 0, 5'd1, 5'd2, 64'h0,         64'h0,         2'b11, 6));
    vecs.push_back(mk(2'b10, 5'd0, 64'h0,         5'd12, 64'hC, 2'b00, 1, 5'd4, 1, 5'd3, 5'd4, 64'h22,        64'h0,         2'b01, 6));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd3, 5'd4, 64'h22,        64'h0,         2'b00, 7));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd1, 5'd12, 64'h0,        64'hC,         2'b00, 7));
    vecs.push_back(mk(2'b11, 5'd0, 64'h5,         5'd20, 64'h14, 2'b00, 0, 5'd0, 0, 5'd20, 5'd0, 64'h14,      64'h0,         2'b00, 7));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 0, 5'd0, 0, 5'd20, 5'd31, 64'h14,      64'h0,         2'b00, 8));
    vecs.push_back(mk(2'b00, 5'd0, 64'h0,         5'd0, 64'h0,  2'b00, 1, 5'd9, 0, 5'd5, 5'd3, 64'hDEADBEEF,  64'h22,        2'b00, 8));

    rst = 1'b1;
    applyStimulus(vecs[0]);
    #12;
    checkAll("in_reset", 64'h0, 64'h0, 2'b00, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkAll($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].ec);
    end

    // After the last row's issue of x9: busy x9 visible, then async reset mid-cycle.
    @(negedge clk);
    applyStimulus(mk(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 0, 5'd0, 0,
                     5'd9, 5'd5, 64'h0, 64'h0, 2'b00, 0));
    #2;
    checkOutput("pre_rst busy", {62'd0, rd_busy_o}, {62'd0, 2'b01});
    checkOutput("pre_rst rd1", rd_data_o[XLEN +: XLEN], 64'hDEADBEEF);
    checkOutput("pre_rst cnt", {32'd0, commit_cnt_o}, 64'd8);
    #1;
    rst = 1'b1;
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd5};
    wr_data_i = {64'h0, 64'h123};
    #1;
    checkAll("async_rst", 64'h0, 64'h0, 2'b00, 32'd0);
    @(negedge clk);
    applyStimulus(mk(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 0, 5'd0, 0,
                     5'd5, 5'd3, 64'h0, 64'h0, 2'b00, 0));
    rst = 1'b0;
    #2;
    checkAll("post_rst", 64'h0, 64'h0, 2'b00, 32'd0);

    // A write right after reset release lands normally.
    @(negedge clk);
    applyStimulus(mk(2'b10, 5'd0, 64'h0, 5'd6, 64'h66, 2'b00, 1, 5'd6, 0,
                     5'd3, 5'd6, 64'h0, 64'h66, 2'b00, 0));
    #2;
    checkAll("post_rst_wr", 64'h0, 64'h66, 2'b00, 32'd0);
    @(negedge clk);
    applyStimulus(mk(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 0, 5'd0, 0,
                     5'd6, 5'd0, 64'h0, 64'h0, 2'b00, 0));
    #2;
    checkAll("post_rst_rd", 64'h66, 64'h0, 2'b01, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
